kernel_m00_axi_cache_read_arbiter: RTL and testbench
====================================================

# kernel_m00_axi_cache_read_arbiter

This block shares the MID-side read port of the M00 system cache among `NUM_REQ` engine requesters. It does this with round-robin arbitration on the read-address channel. Each requester index is encoded into ARID, and read-data beats are steered back to the owner by RID. Per-requester outstanding-burst counters give flow control. No grant is issued while the cache reports initialization.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 64: address width.
- `DATA_W`, 32: cache MID-side data width.
- `ID_W`, 4: cache-port ID width; must be ≥ clog2(`NUM_REQ`).
- `MAX_OUT`, 4: maximum outstanding bursts per requester, 1..15.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- `ap_clk`  in  1  the single clock.
- `areset`  in  1  synchronous, active-high reset.
- `cache_setup_signal`  in  1  high while the cache is initializing; blocks new grants.
- `req_arvalid`  in  NUM_REQ  per-requester AR valid.
- `req_araddr`  in  NUM_REQ*ADDR_W  per-requester address; requester i uses slice i.
- `req_arlen`  in  NUM_REQ*8  per-requester burst length.
- `req_arready`  out  NUM_REQ  AR ready; one-hot or zero.
- `req_rvalid`  out  NUM_REQ  R valid; one-hot or zero.
- `req_rdata`  out  DATA_W  R data, broadcast to all requesters.
- `req_rlast`  out  1  R last, broadcast.
- `req_rready`  in  NUM_REQ  per-requester R ready.
- `m_arvalid`  out  1  cache-port AR valid.
- `m_araddr`  out  ADDR_W  cache-port AR address.
- `m_arlen`  out  8  cache-port AR burst length.
- `m_arid`  out  ID_W  cache-port AR ID.
- `m_arready`  in  1  cache-port AR ready.
- `m_rvalid`  in  1  cache-port R valid.
- `m_rdata`  in  DATA_W  cache-port R data.
- `m_rid`  in  ID_W  cache-port R ID.
- `m_rlast`  in  1  cache-port R last.
- `m_rready`  out  1  cache-port R ready.
- `busy`  out  1  high when state is ISSUE or any outstanding counter is non-zero.
- `err_bad_rid`  out  1  sticky flag: an R beat arrived with `m_rid` ≥ `NUM_REQ`.

## Operation
- **FSM states:** IDLE and ISSUE.
- **Eligibility:** requester i is eligible when `req_arvalid[i]` is high and `cnt[i] < MAX_OUT`.
- **IDLE, grant:** when `cache_setup_signal` is 0 and at least one requester is eligible, grant the first eligible index g searching from `ptr` upward with wrap-around.
  - `req_arready[g]` is driven combinationally.
  - On that edge, capture `req_araddr[g]` into `m_araddr`, `req_arlen[g]` into `m_arlen`, and g zero-extended to `ID_W` into `m_arid`.
  - Move to ISSUE.
- **IDLE, no grant:** when `cache_setup_signal` is 1, or no requester is eligible, `req_arready` = 0 and the FSM stays in IDLE.
- **ISSUE:**
  - `m_arvalid` = 1, and the captured address, length and ID are held stable until `m_arready` is high.
  - On the `m_arready` handshake: `cnt[g]` increments, `ptr` becomes (g+1) mod `NUM_REQ`, and the FSM returns to IDLE.
  - `cache_setup_signal` rising while in ISSUE does not cancel the pending AR.
- **R routing, valid RID:** with `r = m_rid`, when r < `NUM_REQ`:
  - `req_rvalid[r] = m_rvalid` and `m_rready = req_rready[r]`; all other `req_rvalid` bits are 0.
  - `req_rdata` = `m_rdata` and `req_rlast` = `m_rlast`, driven combinationally.
- **R routing, bad RID:** when r ≥ `NUM_REQ`, `m_rready` = 1 and the beat is dropped. `err_bad_rid` is set on `m_rvalid` and stays set until reset.
- **Counter decrement:** `cnt[r]` decrements when `m_rvalid`, `m_rready` and `m_rlast` are all high and r is valid. The decrement saturates at 0.
- **Same-cycle increment and decrement:** if requester i gets both an AR handshake and an R-last handshake in the same cycle, `cnt[i]` is unchanged. Different requesters update independently.
- **Counter width:** clog2(`MAX_OUT`+1) bits; it never exceeds `MAX_OUT`.

## Timing
- **Reset values:** state = IDLE, `ptr` = 0, all `cnt` = 0, `m_arvalid` = 0, `m_araddr` = 0, `m_arlen` = 0, `m_arid` = 0, `err_bad_rid` = 0, `busy` = 0.
  - The combinational outputs (`req_arready`, `req_rvalid`, `m_rready`) also read 0 while `areset` is high.
- **Reset mid-operation:** a pending AR is abandoned and counters clear. R beats arriving after reset are still routed, and their decrements saturate at 0.
- **AR latency:**
  - Requester handshake at edge T gives `m_arvalid` high in cycle T+1.
  - `m_arready` at edge T+1 lets the FSM accept its next grant in cycle T+2.
  - Peak rate is one AR per 2 cycles.
- **R path latency:** zero-cycle, with no buffering.
- **Grant gating:** `cache_setup_signal` is sampled in the same cycle as the grant decision; a grant happens only when it is 0.

## Test plan
- **Setup gating:** hold `cache_setup_signal`=1 for 20 cycles with `req_arvalid`=4'b1111 → no `req_arready` and `m_arvalid`=0. Release → first grant goes to requester 0, then `m_arvalid`=1 with `m_arid`=0 in the next cycle.
- **Round-robin fairness:** all 4 requesters valid, `m_arready` always 1, R channel idle, `MAX_OUT`=4 → grant order 0,1,2,3,0,1,... with one AR every 2 cycles.
- **Backpressure and counter limit:** requester 2 alone issues 4 ARs with no R traffic → 5th request stalls with `req_arready[2]`=0. One R beat with `rid`=2, `rlast`=1 → `cnt[2]`=3 and the 5th AR is granted.
- **R steering:** with `m_rvalid`=1, `m_rid`=1 and `req_rready`=4'b0010 → `req_rvalid`=4'b0010 and `m_rready`=1. Drop `req_rready[1]` → `m_rready`=0.
- **Simultaneous increment/decrement:** in one cycle, requester 3 completes an AR handshake and an R-last handshake arrives with `rid`=3 → `cnt[3]` unchanged.
- **Bad RID and reset:** beat with `m_rid`=5 and `NUM_REQ`=4 → accepted with `m_rready`=1, and `err_bad_rid`=1 stays set. Assert `areset` while in ISSUE → next cycle `m_arvalid`=0, `err_bad_rid`=0, `busy`=0.

Source files
------------

// File: rtl/kernel_m00_axi_cache_read_arbiter.sv
// Round-robin read arbiter sharing the M00 cache MID-side read port among NUM_REQ engines.
// ARID carries the requester index; R beats are steered back by RID with per-requester outstanding limits.
module kernel_m00_axi_cache_read_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic                      cache_setup_signal,
    input  logic [NUM_REQ-1:0]        req_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]      req_arlen,
    output logic [NUM_REQ-1:0]        req_arready,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_rlast,
    input  logic [NUM_REQ-1:0]        req_rready,
    output logic                      m_arvalid,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic [7:0]                m_arlen,
    output logic [ID_W-1:0]           m_arid,
    input  logic                      m_arready,
    input  logic                      m_rvalid,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [ID_W-1:0]           m_rid,
    input  logic                      m_rlast,
    output logic                      m_rready,
    output logic                      busy,
    output logic                      err_bad_rid
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REQ];
    logic [CNT_W-1:0]    cnt_d [NUM_REQ];
    logic [ADDR_W-1:0]   m_araddr_q, m_araddr_d;
    logic [7:0]          m_arlen_q, m_arlen_d;
    logic [ID_W-1:0]     m_arid_q, m_arid_d;
    logic                err_bad_rid_q, err_bad_rid_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  inc;
    logic [NUM_REQ-1:0]  dec;
    logic                grant_any;
    logic [PTR_W-1:0]    grant_idx;
    logic                rid_ok;

    // Requester may be granted only while below its outstanding-burst limit
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            elig[i] = req_arvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % int'(NUM_REQ);
            if (!grant_any && elig[PTR_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
        if (areset || (state_q != IDLE) || cache_setup_signal) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        req_arready = '0;
        if (grant_any) begin
            req_arready[grant_idx] = 1'b1;
        end
    end

    // R channel: out-of-range IDs are sunk so the cache never stalls on them
    always_comb begin
        rid_ok     = (32'(m_rid) < 32'(NUM_REQ));
        req_rvalid = '0;
        m_rready   = 1'b0;
        dec        = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (rid_ok && (m_rid == ID_W'(i))) begin
                req_rvalid[i] = m_rvalid;
                m_rready      = req_rready[i];
            end
        end
        if (!rid_ok) begin
            m_rready = 1'b1;
        end
        if (areset) begin
            req_rvalid = '0;
            m_rready   = 1'b0;
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            dec[i] = req_rvalid[i] && m_rready && m_rlast;
        end
    end

    assign req_rdata = m_rdata;
    assign req_rlast = m_rlast;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        m_araddr_d    = m_araddr_q;
        m_arlen_d     = m_arlen_q;
        m_arid_d      = m_arid_q;
        err_bad_rid_d = err_bad_rid_q | (m_rvalid && !rid_ok);
        inc           = '0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d    = ISSUE;
                    m_araddr_d = req_araddr[grant_idx*ADDR_W +: ADDR_W];
                    m_arlen_d  = req_arlen[grant_idx*8 +: 8];
                    m_arid_d   = ID_W'(grant_idx);
                end
            end
            ISSUE: begin
                if (m_arready) begin
                    state_d                 = IDLE;
                    inc[PTR_W'(m_arid_q)]   = 1'b1;
                    ptr_d = (m_arid_q == ID_W'(NUM_REQ - 1)) ? '0
                                                            : PTR_W'(m_arid_q) + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous AR and R-last on one requester cancel out
    always_comb begin
        busy_d = (state_d == ISSUE);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cnt_d[i] = cnt_q[i];
            case ({inc[i], dec[i]})
                2'b10:   if (cnt_q[i] < CNT_W'(MAX_OUT)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
            if (cnt_d[i] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            m_araddr_q    <= '0;
            m_arlen_q     <= '0;
            m_arid_q      <= '0;
            err_bad_rid_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            m_araddr_q    <= m_araddr_d;
            m_arlen_q     <= m_arlen_d;
            m_arid_q      <= m_arid_d;
            err_bad_rid_q <= err_bad_rid_d;
            busy_q        <= busy_d;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign m_arvalid   = (state_q == ISSUE);
    assign m_araddr    = m_araddr_q;
    assign m_arlen     = m_arlen_q;
    assign m_arid      = m_arid_q;
    assign err_bad_rid = err_bad_rid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_kernel_m00_axi_cache_read_arbiter.sv
// Bench for the cache read arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_kernel_m00_axi_cache_read_arbiter;

    localparam int NR = 4;
    localparam int MO = 4;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int IW = 4;

    logic              ap_clk = 1'b0;
    logic              areset;
    logic              cache_setup_signal;
    logic [NR-1:0]     req_arvalid;
    logic [NR*AW-1:0]  req_araddr;
    logic [NR*8-1:0]   req_arlen;
    logic [NR-1:0]     req_arready;
    logic [NR-1:0]     req_rvalid;
    logic [DW-1:0]     req_rdata;
    logic              req_rlast;
    logic [NR-1:0]     req_rready;
    logic              m_arvalid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [IW-1:0]     m_arid;
    logic              m_arready;
    logic              m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic [IW-1:0]     m_rid;
    logic              m_rlast;
    logic              m_rready;
    logic              busy;
    logic              err_bad_rid;

    kernel_m00_axi_cache_read_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUT(MO)
    ) dut (
        .ap_clk(ap_clk), .areset(areset), .cache_setup_signal(cache_setup_signal),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
        .req_rlast(req_rlast), .req_rready(req_rready), .m_arvalid(m_arvalid),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast),
        .m_rready(m_rready), .busy(busy), .err_bad_rid(err_bad_rid)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] addr_of(input int i);
        return 64'h8000_0000_0000_0040 | (64'(i) << 12);
    endfunction

    // Transaction-level model: outstanding counts, rotating priority, one pending AR
    int          mdl_cnt [NR];
    int          mdl_ptr  = 0;
    bit          mdl_pend = 0;
    int          mdl_g    = 0;
    logic [63:0] mdl_addr = '0;
    logic [7:0]  mdl_len  = '0;
    bit          mdl_err  = 0;

    int grant_q[$];
    int grant_cyc[$];

    always @(posedge ap_clk) cyc++;

    always @(negedge ap_clk) begin
        int          g_new, r, inc_i, dec_r, nv;
        logic [NR-1:0] e_arready, e_rvalid;
        logic        e_rready;
        bit          any_cnt;

        g_new = -1;
        if (!areset && !mdl_pend && !cache_setup_signal) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (mdl_ptr + k) % NR;
                if (g_new < 0 && req_arvalid[idx] && mdl_cnt[idx] < MO) g_new = idx;
            end
        end
        e_arready = '0;
        if (g_new >= 0) e_arready[g_new] = 1'b1;

        r = int'(m_rid);
        if (r < NR) begin
            e_rvalid = m_rvalid ? NR'(1 << r) : '0;
            e_rready = req_rready[r];
        end else begin
            e_rvalid = '0;
            e_rready = 1'b1;
        end
        if (areset) begin
            e_rvalid = '0;
            e_rready = 1'b0;
        end

        any_cnt = 0;
        for (int i = 0; i < NR; i++) if (mdl_cnt[i] != 0) any_cnt = 1;

        check("req_arready", 64'(req_arready), 64'(e_arready));
        check("req_rvalid",  64'(req_rvalid),  64'(e_rvalid));
        check("m_rready",    64'(m_rready),    64'(e_rready));
        check("req_rdata",   64'(req_rdata),   64'(m_rdata));
        check("req_rlast",   64'(req_rlast),   64'(m_rlast));
        check("m_arvalid",   64'(m_arvalid),   64'(mdl_pend));
        check("m_araddr",    64'(m_araddr),    mdl_addr);
        check("m_arlen",     64'(m_arlen),     64'(mdl_len));
        check("m_arid",      64'(m_arid),      64'(mdl_g));
        check("busy",        64'(busy),        64'(mdl_pend || any_cnt));
        check("err_bad_rid", 64'(err_bad_rid), 64'(mdl_err));
        for (int i = 0; i < NR; i++)
            check($sformatf("cnt%0d", i), 64'(dut.cnt_q[i]), 64'(mdl_cnt[i]));

        if (req_arready != '0) begin
            for (int i = 0; i < NR; i++) if (req_arready[i]) grant_q.push_back(i);
            grant_cyc.push_back(cyc);
        end

        // Advance the model to the state after the coming edge
        if (areset) begin
            for (int i = 0; i < NR; i++) mdl_cnt[i] = 0;
            mdl_ptr = 0; mdl_pend = 0; mdl_g = 0; mdl_addr = '0; mdl_len = '0; mdl_err = 0;
        end else begin
            dec_r = (m_rvalid && r < NR && e_rready && m_rlast) ? r : -1;
            inc_i = (mdl_pend && m_arready) ? mdl_g : -1;
            for (int i = 0; i < NR; i++) begin
                nv = mdl_cnt[i] + ((i == inc_i) ? 1 : 0) - ((i == dec_r) ? 1 : 0);
                mdl_cnt[i] = (nv < 0) ? 0 : nv;
            end
            if (m_rvalid && r >= NR) mdl_err = 1;
            if (inc_i >= 0) begin
                mdl_ptr  = (mdl_g + 1) % NR;
                mdl_pend = 0;
            end
            if (g_new >= 0) begin
                mdl_pend = 1;
                mdl_g    = g_new;
                mdl_addr = addr_of(g_new);
                mdl_len  = 8'(g_new * 16 + 3);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_r();
        m_rvalid = 1'b0; m_rid = '0; m_rlast = 1'b0; req_rready = '0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) mdl_cnt[i] = 0;
        areset = 1'b1; cache_setup_signal = 1'b0; req_arvalid = '0;
        m_arready = 1'b0; m_rdata = 32'h0; clear_r();
        for (int i = 0; i < NR; i++) begin
            req_araddr[i*AW +: AW] = addr_of(i);
            req_arlen[i*8 +: 8]    = 8'(i * 16 + 3);
        end
        tick(3);
        check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        areset = 1'b0;

        // Setup gating, then release
        cache_setup_signal = 1'b1; req_arvalid = 4'b1111;
        tick(20);
        check("setup_arready", 64'(req_arready), 64'd0);
        check("setup_arvalid", 64'(m_arvalid),   64'd0);
        grant_q.delete(); grant_cyc.delete();
        cache_setup_signal = 1'b0;
        #1;
        check("release_arready", 64'(req_arready), 64'b0001);
        tick(1);
        check("release_arvalid", 64'(m_arvalid), 64'd1);
        check("release_arid",    64'(m_arid),    64'd0);
        check("release_araddr",  64'(m_araddr),  64'h8000_0000_0000_0040);

        // Round robin until every requester hits its limit
        m_arready = 1'b1;
        tick(40);
        check("rr_count", 64'(grant_q.size()), 64'd16);
        for (int i = 0; i < grant_q.size() && i < 16; i++) begin
            check($sformatf("rr_order%0d", i), 64'(grant_q[i]), 64'(i % NR));
            if (i > 0) check($sformatf("rr_gap%0d", i), 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd2);
        end
        check("rr_stalled", 64'(req_arready), 64'd0);
        check("rr_busy",    64'(busy),        64'd1);

        req_arvalid = '0; m_arready = 1'b0; areset = 1'b1;
        tick(2);
        areset = 1'b0;
        check("rr_reset_busy", 64'(busy), 64'd0);

        // Backpressure on requester 2 at its limit, released by one R-last
        req_arvalid = 4'b0100; m_arready = 1'b1;
        tick(12);
        check("bp_arready", 64'(req_arready), 64'd0);
        check("bp_mdl_cnt", 64'(mdl_cnt[2]), 64'd4);
        m_rvalid = 1'b1; m_rid = 4'd2; m_rlast = 1'b1; req_rready = 4'b0100; m_rdata = 32'hDEAD_BEEF;
        #1;
        check("bp_rvalid",  64'(req_rvalid),  64'b0100);
        check("bp_rready",  64'(m_rready),    64'd1);
        check("bp_rdata",   64'(req_rdata),   64'hDEAD_BEEF);
        check("bp_arready2",64'(req_arready), 64'd0);
        tick(1);
        clear_r();
        #1;
        check("bp_mdl_cnt3", 64'(mdl_cnt[2]), 64'd3);
        check("bp_grant5",   64'(req_arready), 64'b0100);
        tick(1);
        req_arvalid = '0;
        check("bp_arid",   64'(m_arid),   64'd2);
        check("bp_araddr", 64'(m_araddr), 64'h8000_0000_0000_2040);
        check("bp_arlen",  64'(m_arlen),  64'd35);
        tick(2);

        // R steering to requester 1
        m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b0; req_rready = 4'b0010; m_rdata = 32'h1234_5678;
        #1;
        check("steer_rvalid", 64'(req_rvalid), 64'b0010);
        check("steer_rready", 64'(m_rready),   64'd1);
        req_rready = 4'b0000;
        #1;
        check("steer_rready0", 64'(m_rready), 64'd0);
        tick(1);
        clear_r();

        // Simultaneous AR handshake and R-last on requester 3
        req_arvalid = 4'b1000; m_arready = 1'b1;
        tick(1);
        req_arvalid = '0;
        tick(1);
        req_arvalid = 4'b1000; m_arready = 1'b0;
        tick(1);
        req_arvalid = '0;
        check("sim_pending", 64'(m_arvalid), 64'd1);
        m_arready = 1'b1; m_rvalid = 1'b1; m_rid = 4'd3; m_rlast = 1'b1; req_rready = 4'b1000;
        tick(1);
        clear_r(); m_arready = 1'b0;
        check("sim_mdl_cnt", 64'(mdl_cnt[3]), 64'd1);
        tick(2);

        // Bad RID, then reset while an AR is pending
        m_rvalid = 1'b1; m_rid = 4'd5; m_rlast = 1'b1;
        #1;
        check("bad_rready", 64'(m_rready),   64'd1);
        check("bad_rvalid", 64'(req_rvalid), 64'd0);
        tick(1);
        clear_r();
        tick(3);
        check("bad_sticky", 64'(err_bad_rid), 64'd1);
        req_arvalid = 4'b0001;
        tick(1);
        req_arvalid = '0;
        check("issue_before_rst", 64'(m_arvalid), 64'd1);
        areset = 1'b1;
        #1;
        check("rst_comb_arready", 64'(req_arready), 64'd0);
        tick(1);
        areset = 1'b0;
        check("rst_arvalid", 64'(m_arvalid),   64'd0);
        check("rst_err",     64'(err_bad_rid), 64'd0);
        check("rst_busy2",   64'(busy),        64'd0);

        // Late R-last after reset: routed, counter stays at zero
        m_rvalid = 1'b1; m_rid = 4'd0; m_rlast = 1'b1; req_rready = 4'b0001;
        #1;
        check("late_rvalid", 64'(req_rvalid), 64'b0001);
        tick(1);
        clear_r();
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
